// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared header fields, state encoding and header packing for the router packet source
package router_pkg;

   localparam int LEN_W  = 6;
   localparam int ADDR_W = 2;
   localparam int HDR_W  = LEN_W + ADDR_W;

   localparam logic [ADDR_W-1:0] MAX_PORT = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } state_t;

   function automatic logic [HDR_W-1:0] pack_header(
      input logic [LEN_W-1:0]  len,
      input logic [ADDR_W-1:0] addr
   );
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - single-pass payload buffer with independent write and read pointers
// No full/empty tracking: the packet FSM bounds every write and read.
module router_tx_buf #(
   parameter int DEPTH = 64
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_clr,
   input  logic       i_wr_en,
   input  logic [7:0] i_wr_data,
   input  logic       i_rd_en,
   output logic [7:0] o_rd_data
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - buffers a payload, then emits header, payload and parity to the router input port
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int IPG   = 2,
   parameter int DEPTH = 64
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_dest_addr,
   input  logic [LEN_W-1:0]  i_payload_len,
   input  logic              i_corrupt_parity,
   output logic              o_req_ready,
   output logic              o_req_err,
   input  logic [7:0]        i_pl_data,
   input  logic              i_pl_valid,
   output logic              o_pl_ready,
   input  logic              i_busy,
   output logic              o_pkt_valid,
   output logic [7:0]        o_data_out,
   output logic              o_pkt_done
);

   state_t             r_state, w_next;
   logic [HDR_W-1:0]   r_hdr;
   logic [7:0]         r_par;
   logic               r_corrupt;
   logic [LEN_W-1:0]   r_cnt;
   logic [15:0]        r_gap;

   logic [LEN_W-1:0]   w_len;
   logic [7:0]         w_par_out;
   logic [7:0]         w_rd_data;
   logic               w_req_ok, w_accept, w_xfer, w_last_load, w_consume, w_gap_done;
   logic               w_rd_en;
   logic [7:0]         w_data_nxt;
   logic               w_valid_nxt, w_done_nxt, w_req_err_nxt;

   assign w_len       = r_hdr[HDR_W-1:ADDR_W];
   assign w_par_out   = {r_par[7:1], r_par[0] ^ r_corrupt};
   assign w_req_ok    = (i_payload_len != '0) && (i_dest_addr <= MAX_PORT);
   assign w_accept    = (r_state == ST_IDLE) && i_start && w_req_ok;
   assign w_xfer      = (r_state == ST_LOAD) && i_pl_valid && o_pl_ready;
   assign w_last_load = w_xfer && ((r_cnt + 1'b1) == w_len);
   assign w_consume   = !i_busy;
   assign w_gap_done  = (r_gap == 16'(IPG - 1));

   router_tx_buf #(.DEPTH(DEPTH)) u_buf (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clr     (w_accept),
      .i_wr_en   (w_xfer),
      .i_wr_data (i_pl_data),
      .i_rd_en   (w_rd_en),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_LOAD;
         ST_LOAD:    if (w_last_load) w_next = ST_HEADER;
         ST_HEADER:  if (w_consume) w_next = ST_PAYLOAD;
         ST_PAYLOAD: if (w_consume && (r_cnt == w_len)) w_next = ST_PARITY;
         ST_PARITY:  if (w_consume) w_next = (IPG == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:     if (w_gap_done) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs; data_out and pkt_valid hold unless a byte is consumed.
   always_comb begin
      w_data_nxt    = o_data_out;
      w_valid_nxt   = o_pkt_valid;
      w_done_nxt    = 1'b0;
      w_rd_en       = 1'b0;
      w_req_err_nxt = (r_state == ST_IDLE) && i_start && !w_req_ok;
      case (r_state)
         ST_LOAD: begin
            if (w_last_load) begin
               w_data_nxt  = r_hdr;
               w_valid_nxt = 1'b1;
            end
         end
         ST_HEADER: begin
            if (w_consume) begin
               w_data_nxt = w_rd_data;
               w_rd_en    = 1'b1;
            end
         end
         ST_PAYLOAD: begin
            if (w_consume) begin
               if (r_cnt == w_len) begin
                  w_data_nxt  = w_par_out;
                  w_valid_nxt = 1'b0;
               end else begin
                  w_data_nxt = w_rd_data;
                  w_rd_en    = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_consume) begin
               w_data_nxt = 8'h00;
               w_done_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_req_ready <= 1'b1;
         o_req_err   <= 1'b0;
         o_pl_ready  <= 1'b0;
         o_pkt_valid <= 1'b0;
         o_data_out  <= 8'h00;
         o_pkt_done  <= 1'b0;
      end else begin
         o_req_ready <= (w_next == ST_IDLE);
         o_req_err   <= w_req_err_nxt;
         o_pl_ready  <= (w_next == ST_LOAD);
         o_pkt_valid <= w_valid_nxt;
         o_data_out  <= w_data_nxt;
         o_pkt_done  <= w_done_nxt;
      end
   end

   // r_cnt counts bytes written during LOAD, then bytes presented during HEADER/PAYLOAD.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_hdr     <= '0;
         r_par     <= 8'h00;
         r_corrupt <= 1'b0;
         r_cnt     <= '0;
         r_gap     <= '0;
      end else begin
         if (w_accept) begin
            r_hdr     <= pack_header(i_payload_len, i_dest_addr);
            r_par     <= pack_header(i_payload_len, i_dest_addr);
            r_corrupt <= i_corrupt_parity;
            r_cnt     <= '0;
         end
         if (w_xfer) begin
            r_par <= r_par ^ i_pl_data;
            r_cnt <= r_cnt + 1'b1;
         end
         if ((r_state == ST_HEADER) && w_consume) r_cnt <= LEN_W'(1);
         if ((r_state == ST_PAYLOAD) && w_consume && (r_cnt != w_len)) r_cnt <= r_cnt + 1'b1;
         if ((r_state == ST_PARITY) && w_consume) r_gap <= '0;
         if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
      end
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic       i_start = 1'b0;
   logic [1:0] i_dest_addr = 2'd0;
   logic [5:0] i_payload_len = 6'd0;
   logic       i_corrupt_parity = 1'b0;
   logic       o_req_ready, o_req_err, o_pl_ready, o_pkt_valid, o_pkt_done;
   logic [7:0] i_pl_data = 8'h00;
   logic       i_pl_valid = 1'b0;
   logic       i_busy = 1'b0;
   logic [7:0] o_data_out;

   int checks = 0;
   int errors = 0;

   logic [7:0] pl_q[$];
   logic [7:0] got[$];
   logic [7:0] par_byte;
   int         valid_cycles, hold_cycles, done_cnt;
   logic       ab_valid;
   logic [7:0] ab_data;

   always #5 i_clk = ~i_clk;

   router_pkt_tx #(.IPG(2), .DEPTH(64)) dut (
      .i_clk            (i_clk),
      .i_rstn           (i_rstn),
      .i_start          (i_start),
      .i_dest_addr      (i_dest_addr),
      .i_payload_len    (i_payload_len),
      .i_corrupt_parity (i_corrupt_parity),
      .o_req_ready      (o_req_ready),
      .o_req_err        (o_req_err),
      .i_pl_data        (i_pl_data),
      .i_pl_valid       (i_pl_valid),
      .o_pl_ready       (o_pl_ready),
      .i_busy           (i_busy),
      .o_pkt_valid      (o_pkt_valid),
      .o_data_out       (o_data_out),
      .o_pkt_done       (o_pkt_done)
   );

   task automatic issue_req(input logic [1:0] a, input logic [5:0] l, input logic c);
      int w = 0;
      do begin
         @(negedge i_clk);
         w++;
      end while (!o_req_ready && w < 50);
      checks++;
      if (o_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait got %0b want 1", o_req_ready);
      end
      i_dest_addr = a;
      i_payload_len = l;
      i_corrupt_parity = c;
      i_start = 1'b1;
   endtask

   task automatic load_payload(input int len, input bit keep_start);
      int idx = 0;
      bit xfer;
      for (int c = 0; c < 300 && idx < len; c++) begin
         @(negedge i_clk);
         if (!keep_start) i_start = 1'b0;
         xfer = o_pl_ready;
         i_pl_valid = o_pl_ready;
         i_pl_data = pl_q[idx];
         @(posedge i_clk);
         if (xfer) idx++;
      end
      checks++;
      if (idx != len) begin
         errors++;
         $display("FAIL load_bytes got %0d want %0d", idx, len);
      end
   endtask

   task automatic collect(input logic [7:0] stall_byte, input int stall_cycles, input bit abort);
      int stalled = 0;
      bit par_seen = 0;
      bit fin = 0;
      got.delete();
      valid_cycles = 0;
      hold_cycles = 0;
      done_cnt = 0;
      par_byte = 8'h00;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge i_clk);
         i_pl_valid = 1'b0;
         if (o_pkt_done) begin
            done_cnt++;
            fin = 1;
         end else if (o_pkt_valid) begin
            valid_cycles++;
            if (o_data_out == stall_byte) hold_cycles++;
            if (abort && o_data_out == 8'h07) begin
               #2 i_rstn = 1'b0;
               #1 ab_valid = o_pkt_valid;
               ab_data = o_data_out;
               return;
            end
            if (o_data_out == stall_byte && stalled < stall_cycles) begin
               i_busy = 1'b1;
               stalled++;
            end else begin
               i_busy = 1'b0;
               got.push_back(o_data_out);
            end
         end else if (!par_seen && got.size() > 0) begin
            par_byte = o_data_out;
            par_seen = 1;
            i_busy = 1'b0;
         end
      end
      i_busy = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL pkt_done_wait got 0 want 1");
      end
   endtask

   task automatic test_reset;
      i_rstn = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;
      @(negedge i_clk);
      checks++;
      if ({o_req_ready, o_req_err, o_pl_ready, o_pkt_valid, o_pkt_done} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags got %05b want 10000", {o_req_ready, o_req_err, o_pl_ready, o_pkt_valid, o_pkt_done});
      end
      checks++;
      if (o_data_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got %02h want 00", o_data_out);
      end
   endtask

   task automatic test_reject;
      logic [1:0] addrs [2] = '{2'd1, 2'd3};
      logic [5:0] lens  [2] = '{6'd0, 6'd5};
      for (int k = 0; k < 2; k++) begin
         i_dest_addr = addrs[k];
         i_payload_len = lens[k];
         i_start = 1'b1;
         @(negedge i_clk);
         i_start = 1'b0;
         checks++;
         if ({o_req_err, o_req_ready, o_pkt_valid} !== 3'b110) begin
            errors++;
            $display("FAIL reject_pulse[%0d] err/ready/valid got %03b want 110", k, {o_req_err, o_req_ready, o_pkt_valid});
         end
         @(negedge i_clk);
         checks++;
         if ({o_req_err, o_req_ready, o_pl_ready, o_pkt_valid} !== 4'b0100) begin
            errors++;
            $display("FAIL reject_after[%0d] err/ready/plr/valid got %04b want 0100", k, {o_req_err, o_req_ready, o_pl_ready, o_pkt_valid});
         end
      end
   endtask

   task automatic test_single;
      logic [7:0] exp_b;
      pl_q.delete();
      for (int i = 1; i <= 14; i++) pl_q.push_back(8'(i));
      issue_req(2'd2, 6'd14, 1'b0);
      load_payload(14, 0);
      collect(8'h05, 0, 0);
      checks++;
      if (got.size() != 15) begin
         errors++;
         $display("FAIL single_count got %0d want 15", got.size());
      end
      for (int i = 0; i < got.size() && i < 15; i++) begin
         exp_b = (i == 0) ? 8'h3A : 8'(i);
         checks++;
         if (got[i] !== exp_b) begin
            errors++;
            $display("FAIL single_byte[%0d] got %02h want %02h", i, got[i], exp_b);
         end
      end
      checks++;
      if (valid_cycles != 15) begin
         errors++;
         $display("FAIL single_valid_cycles got %0d want 15", valid_cycles);
      end
      checks++;
      if (par_byte !== 8'h35) begin
         errors++;
         $display("FAIL single_parity got %02h want 35", par_byte);
      end
      checks++;
      if (o_data_out !== 8'h00) begin
         errors++;
         $display("FAIL single_data_after got %02h want 00", o_data_out);
      end
      @(negedge i_clk);
      checks++;
      if (o_pkt_done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_pulse got %0b want 0", o_pkt_done);
      end
   endtask

   task automatic test_busy_hold;
      logic [7:0] exp_b;
      pl_q.delete();
      for (int i = 1; i <= 14; i++) pl_q.push_back(8'(i));
      issue_req(2'd2, 6'd14, 1'b0);
      load_payload(14, 0);
      collect(8'h05, 3, 0);
      checks++;
      if (got.size() != 15) begin
         errors++;
         $display("FAIL busy_count got %0d want 15", got.size());
      end
      for (int i = 0; i < got.size() && i < 15; i++) begin
         exp_b = (i == 0) ? 8'h3A : 8'(i);
         checks++;
         if (got[i] !== exp_b) begin
            errors++;
            $display("FAIL busy_byte[%0d] got %02h want %02h", i, got[i], exp_b);
         end
      end
      checks++;
      if (hold_cycles != 4) begin
         errors++;
         $display("FAIL busy_hold_cycles got %0d want 4", hold_cycles);
      end
      checks++;
      if (valid_cycles != 18) begin
         errors++;
         $display("FAIL busy_valid_cycles got %0d want 18", valid_cycles);
      end
      checks++;
      if (par_byte !== 8'h35) begin
         errors++;
         $display("FAIL busy_parity got %02h want 35", par_byte);
      end
   endtask

   task automatic test_corrupt;
      pl_q.delete();
      pl_q.push_back(8'hAA);
      issue_req(2'd0, 6'd1, 1'b1);
      load_payload(1, 0);
      collect(8'h00, 0, 0);
      checks++;
      if (got.size() != 2) begin
         errors++;
         $display("FAIL corrupt_count got %0d want 2", got.size());
      end else begin
         checks++;
         if (got[0] !== 8'h04 || got[1] !== 8'hAA) begin
            errors++;
            $display("FAIL corrupt_bytes got %02h %02h want 04 aa", got[0], got[1]);
         end
      end
      checks++;
      if (par_byte !== 8'hAF) begin
         errors++;
         $display("FAIL corrupt_parity got %02h want af", par_byte);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL corrupt_done got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid;
      pl_q.delete();
      for (int i = 1; i <= 14; i++) pl_q.push_back(8'(i));
      ab_valid = 1'b1;
      ab_data = 8'hFF;
      issue_req(2'd2, 6'd14, 1'b0);
      load_payload(14, 0);
      collect(8'h00, 0, 1);
      checks++;
      if (ab_valid !== 1'b0 || ab_data !== 8'h00) begin
         errors++;
         $display("FAIL abort_async got valid %0b data %02h want 0 00", ab_valid, ab_data);
      end
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;
      @(negedge i_clk);
      checks++;
      if ({o_req_ready, o_pl_ready, o_pkt_valid} !== 3'b100) begin
         errors++;
         $display("FAIL abort_release ready/plr/valid got %03b want 100", {o_req_ready, o_pl_ready, o_pkt_valid});
      end
      test_single();
   endtask

   task automatic test_back_to_back;
      int first_ready = -1;
      int first_pl = -1;
      pl_q = '{8'h10, 8'h20, 8'h30};
      issue_req(2'd1, 6'd3, 1'b0);
      load_payload(3, 1);
      collect(8'h00, 0, 0);
      checks++;
      if (got.size() != 4 || got[0] !== 8'h0D || par_byte !== 8'h0D) begin
         errors++;
         $display("FAIL b2b_pkt1 got n=%0d hdr %02h par %02h want n=4 hdr 0d par 0d", got.size(), got[0], par_byte);
      end
      pl_q = '{8'h55, 8'h66};
      i_dest_addr = 2'd2;
      i_payload_len = 6'd2;
      for (int k = 1; k <= 10; k++) begin
         @(negedge i_clk);
         if (o_req_ready && first_ready < 0) first_ready = k;
         if (o_pl_ready) begin
            first_pl = k;
            break;
         end
      end
      checks++;
      if (first_ready != 2) begin
         errors++;
         $display("FAIL b2b_ready_cycle got %0d want 2", first_ready);
      end
      checks++;
      if (first_pl != 3) begin
         errors++;
         $display("FAIL b2b_load_cycle got %0d want 3", first_pl);
      end
      load_payload(2, 1);
      collect(8'h00, 0, 0);
      i_start = 1'b0;
      checks++;
      if (got.size() != 3 || got[0] !== 8'h0A || par_byte !== 8'h39) begin
         errors++;
         $display("FAIL b2b_pkt2 got n=%0d hdr %02h par %02h want n=3 hdr 0a par 39", got.size(), got[0], par_byte);
      end
   endtask

   initial begin
      test_reset();
      test_reject();
      test_single();
      test_busy_hold();
      test_corrupt();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
